touch_i2c_slave: RTL
====================

// Module: touch_i2c_slave
// PURPOSE
//  I2C target (responder) that emulates the touch controller seen by the I2C master: decodes START/STOP,
//  matches a 7-bit device address and a 16/8-bit register pointer (auto-increment), and performs
//  burst writes/reads against an external synchronous 8-bit register file. Used as the on-chip
//  touch-panel model for bring-up and as the DUT-side peer in master regressions.
// PARAMETERS
//  SLAVE_ADDR  7'h14  7-bit device address answered (7'h38 for FT-family panels)
//  ADDR_16B    1'b1   1: register pointer = 2 bytes (MSB first); 0: 1 byte, ptr[15:8] forced 0
//  FLT_LEN     3      clk cycles SCL/SDA must be stable before the filtered level changes (2..7)
// PORTS
//  clk        in   1   system clock, >= 20x SCL frequency (100 MHz nominal)
//  rst_n      in   1   synchronous active-low reset
//  scl        in   1   I2C clock from master (asynchronous)
//  sda_in     in   1   I2C data pad input (asynchronous)
//  sda_out    out  1   pad drive value; constant 0 (open-drain)
//  sda_dir    out  1   1 = pull SDA low; 0 = release
//  reg_addr   out  16  register pointer for current access
//  reg_wr_en  out  1   one-cycle write strobe; reg_wdata valid with it
//  reg_wdata  out  8   byte received from master
//  reg_rd_en  out  1   one-cycle read request; reg_rdata must be valid the next cycle
//  reg_rdata  in   8   byte returned by register file
//  busy       out  1   1 from START to STOP (bus owned by a master)
//  selected   out  1   1 from address-match ACK to next START/STOP
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): sda_dir=0, reg_addr=0, reg_wr_en=0, reg_rd_en=0, reg_wdata=0,
//    busy=0, selected=0, FSM=IDLE, filtered scl/sda = 1. Reset mid-transfer releases SDA immediately.
//  - Input path: 2-flop synchronizer then FLT_LEN stability filter; edges detected on filtered levels.
//  - START: filtered SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Either is honoured in ANY state
//    (incl. mid-byte); START -> DEV_ADDR, STOP -> IDLE; both release SDA, clear selected. reg_addr kept.
//  - Bits sampled on filtered SCL rising edge, MSB first. SDA changed only on the cycle after filtered
//    SCL falling edge is detected; held until the next falling edge.
//  - FSM: IDLE -> DEV_ADDR (8 bits) -> DEV_ACK. Address mismatch: no ACK, go IDLE-wait-START (ignore
//    bus until next START). Match+W: -> PTR_H/ACK -> PTR_L/ACK (PTR_H skipped if ADDR_16B=0) ->
//    WR_DATA/WR_ACK loop. Match+R: -> RD_DATA/RD_MACK loop.
//  - ACK: sda_dir=1 for exactly one SCL period (falling edge after 8th bit to next falling edge).
//  - Write: each completed data byte -> reg_wr_en pulse with reg_addr=current ptr, then ptr+1 after ACK.
//    Pointer bytes never produce reg_wr_en. ptr wraps 16'hFFFF->0 (8'hFF->0 when ADDR_16B=0).
//  - Read: reg_rd_en pulsed at SCL rising of DEV_ACK (and of each master ACK); byte latched next cycle
//    into shift reg; bit7 presented at following SCL falling edge. sda_dir = ~bit. ptr+1 per byte sent.
//    Master NACK (SDA=1 at 9th rise) -> IDLE-wait, no further reg_rd_en, ptr still incremented for byte sent.
//  - Repeated START after pointer write keeps ptr (standard write-ptr/read-data sequence).
//  - reg_wr_en and reg_rd_en never asserted in the same cycle; at most one per byte.
//  - Clock stretching not supported; SCL never driven.
// TESTING
//  1 Write S,0x28,0x81,0x40,0xAA,0x55,P (ADDR 0x14,16b) -> ACK on all 5 bytes; reg_wr_en x2: (0x8140,0xAA),(0x8141,0x55); busy 1->0.
//  2 Ptr write 0x81,0x4E then Sr,0x29, read 3 bytes (rdata = addr[7:0]) -> SDA bytes 0x4E,0x4F,0x50; NACK after 3rd -> SDA released, 3 reg_rd_en.
//  3 S,0x70 (addr 0x38 != 0x14) + 2 bytes -> no ACK (sda_dir stays 0), no strobes, selected=0.
//  4 STOP injected after 4 bits of data byte -> no reg_wr_en, FSM IDLE, sda_dir=0; next full write works.
//  5 Ptr 0xFFFF, write 0x11,0x22 -> strobes at 0xFFFF then 0x0000; ADDR_16B=0 ptr 0xFF -> 0xFF,0x00.
//  6 rst_n=0 while slave drives ACK/read bit 0 -> sda_dir=0 next clk; 1 ns glitch on SCL < FLT_LEN -> no bit sampled.

Source files
------------

// File: rtl/touch_i2c_slave.sv
// I2C target emulating a touch-panel controller: START/STOP decode, 7-bit address match,
// 16/8-bit auto-incrementing register pointer, burst access to an external 8-bit register file.
`timescale 1ns/1ps

module touch_i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h14,
   parameter bit         ADDR_16B   = 1'b1,
   parameter int         FLT_LEN    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl,
   input  logic        sda_in,
   output logic        sda_out,
   output logic        sda_dir,
   output logic [15:0] reg_addr,
   output logic        reg_wr_en,
   output logic [7:0]  reg_wdata,
   output logic        reg_rd_en,
   input  logic [7:0]  reg_rdata,
   output logic        busy,
   output logic        selected
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_DEV_ACK,
      ST_PTR_H,
      ST_PTR_ACK_H,
      ST_PTR_L,
      ST_PTR_ACK_L,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_MACK
   } state_t;

   localparam logic [2:0] CNT_MAX = 3'(FLT_LEN - 1);

   // Index 0 carries SCL, index 1 carries SDA through synchronizer and filter.
   logic [1:0]      sync1_q, sync2_q, flt_q, flt_d, prev_q;
   logic [1:0][2:0] cnt_q, cnt_d;

   state_t      state_q;
   logic [3:0]  bit_cnt_q;
   logic [7:0]  shift_q;
   logic        ack_on_q;
   logic        rw_q;
   logic        rd_lat_q;
   logic        sda_dir_q;
   logic [15:0] reg_addr_q;
   logic        wr_en_q;
   logic [7:0]  wdata_q;
   logic        rd_en_q;
   logic        busy_q;
   logic        selected_q;

   logic        scl_f, sda_f, scl_p, sda_p;
   logic        scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]  byte_d;
   logic [15:0] ptr_inc_d;

   // NOTE: every variable written here gets a value before any branch so no latch is inferred.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         flt_d[i] = flt_q[i];
         cnt_d[i] = 3'd0;
         if (sync2_q[i] != flt_q[i]) begin
            if (cnt_q[i] == CNT_MAX) flt_d[i] = sync2_q[i];
            else                     cnt_d[i] = cnt_q[i] + 3'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         flt_q   <= 2'b11;
         prev_q  <= 2'b11;
         cnt_q   <= '0;
      end else begin
         sync1_q <= {sda_in, scl};
         sync2_q <= sync1_q;
         flt_q   <= flt_d;
         prev_q  <= flt_q;
         cnt_q   <= cnt_d;
      end
   end

   assign scl_f     = flt_q[0];
   assign sda_f     = flt_q[1];
   assign scl_p     = prev_q[0];
   assign sda_p     = prev_q[1];
   assign scl_rise  = scl_f & ~scl_p;
   assign scl_fall  = ~scl_f & scl_p;
   assign start_det = scl_f & scl_p & sda_p & ~sda_f;
   assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;
   assign byte_d    = {shift_q[6:0], sda_f};
   assign ptr_inc_d = ADDR_16B ? reg_addr_q + 16'd1 : {8'h00, reg_addr_q[7:0] + 8'd1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ack_on_q   <= 1'b0;
         rw_q       <= 1'b0;
         rd_lat_q   <= 1'b0;
         sda_dir_q  <= 1'b0;
         reg_addr_q <= '0;
         wr_en_q    <= 1'b0;
         wdata_q    <= '0;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         selected_q <= 1'b0;
      end else begin
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_lat_q <= rd_en_q;
         // Register file answers one cycle after the request; capture it the cycle after that.
         if (rd_lat_q) shift_q <= reg_rdata;

         if (start_det) begin
            state_q    <= ST_DEV_ADDR;
            bit_cnt_q  <= '0;
            ack_on_q   <= 1'b0;
            sda_dir_q  <= 1'b0;
            selected_q <= 1'b0;
            busy_q     <= 1'b1;
         end else if (stop_det) begin
            state_q    <= ST_IDLE;
            ack_on_q   <= 1'b0;
            sda_dir_q  <= 1'b0;
            selected_q <= 1'b0;
            busy_q     <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: ;

               ST_DEV_ADDR, ST_PTR_H, ST_PTR_L, ST_WR_DATA: begin
                  if (scl_rise) begin
                     shift_q   <= byte_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     ack_on_q  <= 1'b0;
                     if (bit_cnt_q == 4'd7) begin
                        case (state_q)
                           ST_DEV_ADDR: state_q <= ST_DEV_ACK;
                           ST_PTR_H: begin
                              reg_addr_q[15:8] <= byte_d;
                              state_q          <= ST_PTR_ACK_H;
                           end
                           ST_PTR_L: begin
                              reg_addr_q <= ADDR_16B ? {reg_addr_q[15:8], byte_d} : {8'h00, byte_d};
                              state_q    <= ST_PTR_ACK_L;
                           end
                           default: begin
                              wr_en_q <= 1'b1;
                              wdata_q <= byte_d;
                              state_q <= ST_WR_ACK;
                           end
                        endcase
                     end
                  end
               end

               ST_DEV_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on_q) begin
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                           ack_on_q   <= 1'b1;
                           sda_dir_q  <= 1'b1;
                           selected_q <= 1'b1;
                           rw_q       <= shift_q[0];
                        end else begin
                           state_q <= ST_IDLE;
                        end
                     end else begin
                        ack_on_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        if (rw_q) begin
                           sda_dir_q <= ~shift_q[7];
                           state_q   <= ST_RD_DATA;
                        end else begin
                           sda_dir_q <= 1'b0;
                           state_q   <= ADDR_16B ? ST_PTR_H : ST_PTR_L;
                        end
                     end
                  end else if (scl_rise && ack_on_q && rw_q) begin
                     rd_en_q <= 1'b1;
                  end
               end

               ST_PTR_ACK_H, ST_PTR_ACK_L, ST_WR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on_q) begin
                        ack_on_q  <= 1'b1;
                        sda_dir_q <= 1'b1;
                     end else begin
                        ack_on_q  <= 1'b0;
                        sda_dir_q <= 1'b0;
                        bit_cnt_q <= '0;
                        case (state_q)
                           ST_PTR_ACK_H: state_q <= ST_PTR_L;
                           ST_PTR_ACK_L: state_q <= ST_WR_DATA;
                           default: begin
                              reg_addr_q <= ptr_inc_d;
                              state_q    <= ST_WR_DATA;
                           end
                        endcase
                     end
                  end
               end

               ST_RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_dir_q  <= 1'b0;
                        reg_addr_q <= ptr_inc_d;
                        state_q    <= ST_RD_MACK;
                     end else begin
                        shift_q   <= {shift_q[6:0], 1'b1};
                        sda_dir_q <= ~shift_q[6];
                     end
                  end
               end

               ST_RD_MACK: begin
                  if (scl_rise) begin
                     if (sda_f) state_q <= ST_IDLE;
                     else       rd_en_q <= 1'b1;
                  end else if (scl_fall) begin
                     sda_dir_q <= ~shift_q[7];
                     bit_cnt_q <= '0;
                     state_q   <= ST_RD_DATA;
                  end
               end

               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign sda_out   = 1'b0;
   assign sda_dir   = sda_dir_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wr_en = wr_en_q;
   assign reg_wdata = wdata_q;
   assign reg_rd_en = rd_en_q;
   assign busy      = busy_q;
   assign selected  = selected_q;

endmodule
